cpu_ad48_irq_ctrl: RTL and testbench

//  Interrupt controller directly upstream of cpu_ad48. It synchronises the raw

---
 rtl/cpu_ad48_irq_pkg.sv | 23 ++
 rtl/cpu_ad48_irq_sync.sv | 28 ++
 rtl/cpu_ad48_irq_ctrl.sv | 159 +++++++++++++++
 tb/tb_cpu_ad48_irq_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ad48_irq_pkg.sv
// Shared definitions for the cpu_ad48 interrupt controller: FSM encoding,
// config register map and the default trap-cause base.
package cpu_ad48_irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } irq_state_e;

   localparam logic [1:0] CFG_ENABLE    = 2'd0;
   localparam logic [1:0] CFG_EDGE_MODE = 2'd1;
   localparam logic [1:0] CFG_PEND_CLR  = 2'd2;
   localparam logic [1:0] CFG_PENDING   = 2'd3;

   localparam logic [3:0] CAUSE_IRQ_BASE_DEF = 4'd8;

   // 4-bit cause arithmetic wraps mod 16 by construction.
   function automatic logic [3:0] irq_cause_of(input logic [3:0] base, input logic [3:0] id);
      return base + id;
   endfunction

endpackage

// File: rtl/cpu_ad48_irq_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset to 0.
module cpu_ad48_irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/cpu_ad48_irq_ctrl.sv
// Interrupt controller feeding cpu_ad48 trap logic: synchronise, latch pending,
// pick the highest-priority enabled line and run a non-nesting req/ack/done handshake.
module cpu_ad48_irq_ctrl
   import cpu_ad48_irq_pkg::*;
#(
   parameter int         IRQ_LINES      = 4,
   parameter int         SYNC_STAGES    = 2,
   parameter logic [3:0] CAUSE_IRQ_BASE = CAUSE_IRQ_BASE_DEF,
   localparam int        ID_W           = (IRQ_LINES > 1) ? $clog2(IRQ_LINES) : 1
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [IRQ_LINES-1:0] irq_in,
   input  logic                 cfg_we,
   input  logic [1:0]           cfg_addr,
   input  logic [IRQ_LINES-1:0] cfg_wdata,
   output logic [IRQ_LINES-1:0] cfg_rdata,
   output logic                 irq_req,
   output logic [ID_W-1:0]      irq_id,
   output logic [3:0]           irq_cause,
   input  logic                 irq_ack,
   input  logic                 irq_done
);

   logic [IRQ_LINES-1:0] s;
   logic [IRQ_LINES-1:0] s_d_q;
   logic [IRQ_LINES-1:0] enable_q,    enable_d;
   logic [IRQ_LINES-1:0] edge_mode_q, edge_mode_d;
   logic [IRQ_LINES-1:0] pending_q,   pending_d;
   logic [IRQ_LINES-1:0] w1c_clr;
   logic [IRQ_LINES-1:0] ack_clr;
   irq_state_e           state_q,     state_d;
   logic [ID_W-1:0]      irq_id_q,    irq_id_d;
   logic                 irq_req_q,   irq_req_d;
   logic                 cand_valid;
   logic [ID_W-1:0]      cand_id;
   logic                 latched_live;

   genvar gi;
   generate
      for (gi = 0; gi < IRQ_LINES; gi++) begin : g_line
         logic rise;
         logic clr;

         cpu_ad48_irq_sync #(
            .STAGES (SYNC_STAGES)
         ) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .d      (irq_in[gi]),
            .q      (s[gi])
         );

         // Edge lines: a new rising edge beats any clear arriving the same cycle.
         assign rise          = s[gi] & ~s_d_q[gi];
         assign clr           = w1c_clr[gi] | ack_clr[gi];
         assign pending_d[gi] = edge_mode_q[gi] ? (rise | (pending_q[gi] & ~clr)) : s[gi];
      end
   endgenerate

   always_comb begin
      enable_d    = enable_q;
      edge_mode_d = edge_mode_q;
      w1c_clr     = '0;
      if (cfg_we) begin
         case (cfg_addr)
            CFG_ENABLE:    enable_d    = cfg_wdata;
            CFG_EDGE_MODE: edge_mode_d = cfg_wdata;
            CFG_PEND_CLR:  w1c_clr     = cfg_wdata;
            default:       ;
         endcase
      end
   end

   always_comb begin
      case (cfg_addr)
         CFG_ENABLE:    cfg_rdata = enable_q;
         CFG_EDGE_MODE: cfg_rdata = edge_mode_q;
         CFG_PENDING:   cfg_rdata = pending_q;
         default:       cfg_rdata = '0;
      endcase
   end

   // Scan downward so the lowest active index is the one left standing.
   always_comb begin
      cand_valid = 1'b0;
      cand_id    = '0;
      for (int i = IRQ_LINES - 1; i >= 0; i--) begin
         if (pending_q[i] && enable_q[i]) begin
            cand_valid = 1'b1;
            cand_id    = ID_W'(i);
         end
      end
   end

   assign latched_live = pending_q[irq_id_q] & enable_q[irq_id_q];

   always_comb begin
      state_d   = state_q;
      irq_id_d  = irq_id_q;
      irq_req_d = irq_req_q;
      ack_clr   = '0;
      case (state_q)
         ST_IDLE: begin
            irq_req_d = 1'b0;
            if (cand_valid) begin
               state_d   = ST_REQ;
               irq_id_d  = cand_id;
               irq_req_d = 1'b1;
            end
         end
         ST_REQ: begin
            if (irq_ack) begin
               state_d           = ST_SERV;
               irq_req_d         = 1'b0;
               ack_clr[irq_id_q] = 1'b1;
            end else if (!latched_live) begin
               state_d   = ST_IDLE;
               irq_req_d = 1'b0;
            end
         end
         ST_SERV: begin
            irq_req_d = 1'b0;
            if (irq_done) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            irq_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s_d_q       <= '0;
         enable_q    <= '0;
         edge_mode_q <= '0;
         pending_q   <= '0;
         state_q     <= ST_IDLE;
         irq_id_q    <= '0;
         irq_req_q   <= 1'b0;
      end else begin
         s_d_q       <= s;
         enable_q    <= enable_d;
         edge_mode_q <= edge_mode_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         irq_id_q    <= irq_id_d;
         irq_req_q   <= irq_req_d;
      end
   end

   assign irq_req   = irq_req_q;
   assign irq_id    = irq_id_q;
   assign irq_cause = irq_cause_of(CAUSE_IRQ_BASE, 4'(irq_id_q));

endmodule

// File: tb/tb_cpu_ad48_irq_ctrl.sv
// Scoreboard bench for cpu_ad48_irq_ctrl: stimulus pushes expected request ids,
// a negedge monitor pops and compares whenever irq_req rises.
module tb_cpu_ad48_irq_ctrl;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [3:0] irq_in = '0;
   logic       cfg_we = 1'b0;
   logic [1:0] cfg_addr = '0;
   logic [3:0] cfg_wdata = '0;
   logic [3:0] cfg_rdata;
   logic       irq_req;
   logic [1:0] irq_id;
   logic [3:0] irq_cause;
   logic       irq_ack = 1'b0;
   logic       irq_done = 1'b0;

   cpu_ad48_irq_ctrl dut (
      .clk       (clk),
      .resetn    (resetn),
      .irq_in    (irq_in),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .irq_req   (irq_req),
      .irq_id    (irq_id),
      .irq_cause (irq_cause),
      .irq_ack   (irq_ack),
      .irq_done  (irq_done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_q[$];
   logic prev_req = 1'b0;
   int mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // Monitor: each new request is one transaction matched against the model queue.
   always @(negedge clk) begin
      if (irq_req && !prev_req) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_req: got request id=%0d, required no request", irq_id);
         end else begin
            mon_e = exp_q.pop_front();
            $display("req  id=%0d cause=%0d (model id=%0d)", irq_id, irq_cause, mon_e);
            check("req_id", 32'(irq_id), 32'(mon_e));
            check("req_cause", 32'(irq_cause), 32'((8 + mon_e) % 16));
         end
      end
      prev_req = irq_req;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_wr(input logic [1:0] a, input logic [3:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      tick(1);
      cfg_we = 1'b0; cfg_wdata = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [3:0] d);
      cfg_addr = a;
      #1;
      d = cfg_rdata;
   endtask

   task automatic pulse(input logic [3:0] m);
      irq_in = m;
      tick(1);
      irq_in = '0;
   endtask

   task automatic do_ack();
      irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
   endtask

   task automatic do_done();
      irq_done = 1'b1; tick(1); irq_done = 1'b0;
   endtask

   task automatic wait_req(input string name, input int budget);
      int k = 0;
      while (!irq_req && k < budget) begin tick(1); k++; end
      check(name, 32'(irq_req), 32'd1);
   endtask

   task automatic wait_low(input string name, input int budget);
      int k = 0;
      while (irq_req && k < budget) begin tick(1); k++; end
      check(name, 32'(irq_req), 32'd0);
   endtask

   logic [3:0] rv;
   logic [3:0] en, pm;
   int nexp;

   initial begin
      tick(2);
      check("rst_req", 32'(irq_req), 32'd0);
      check("rst_id", 32'(irq_id), 32'd0);
      check("rst_cause", 32'(irq_cause), 32'd8);
      rd(2'd0, rv); check("rst_enable", 32'(rv), 32'd0);
      rd(2'd3, rv); check("rst_pending", 32'(rv), 32'd0);
      resetn = 1'b1;
      tick(2);

      // 1: edge line 2, exact 4-edge latency, ack clears pending
      cfg_wr(2'd0, 4'h4); cfg_wr(2'd1, 4'h4);
      exp_q.push_back(2);
      pulse(4'h4);
      tick(2);
      check("t1_not_yet", 32'(irq_req), 32'd0);
      tick(1);
      check("t1_latency", 32'(irq_req), 32'd1);
      do_ack();
      check("t1_req_after_ack", 32'(irq_req), 32'd0);
      rd(2'd3, rv); check("t1_pending_cleared", 32'(rv[2]), 32'd0);
      do_done();
      tick(2);

      // 2: lines 1 and 3 together, priority then one idle cycle
      cfg_wr(2'd0, 4'hA); cfg_wr(2'd1, 4'hA);
      exp_q.push_back(1); exp_q.push_back(3);
      pulse(4'hA);
      wait_req("t2_first", 8);
      do_ack(); do_done();
      check("t2_idle_cycle", 32'(irq_req), 32'd0);
      tick(1);
      check("t2_second_req", 32'(irq_req), 32'd1);
      do_ack(); do_done(); tick(2);

      // 3: level line 0 re-requests while held, withdraws when dropped
      cfg_wr(2'd0, 4'h1); cfg_wr(2'd1, 4'h0);
      exp_q.push_back(0);
      irq_in = 4'h1;
      wait_req("t3_level_req", 8);
      do_ack();
      exp_q.push_back(0);
      do_done();
      wait_req("t3_rereq", 4);
      irq_in = 4'h0;
      wait_low("t3_withdraw", 8);
      tick(3);

      // 4: W1C with ack -> SERV (new pulse held off until done); W1C alone -> withdraw
      cfg_wr(2'd0, 4'h2); cfg_wr(2'd1, 4'h2);
      exp_q.push_back(1);
      pulse(4'h2);
      wait_req("t4_req", 8);
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 4'h2; irq_ack = 1'b1;
      tick(1);
      cfg_we = 1'b0; cfg_wdata = '0; irq_ack = 1'b0;
      check("t4_ack_wins_req", 32'(irq_req), 32'd0);
      pulse(4'h2);
      tick(6);
      check("t4_serv_holds", 32'(irq_req), 32'd0);
      exp_q.push_back(1);
      do_done();
      wait_req("t4_after_done", 4);
      do_ack(); do_done(); tick(2);
      exp_q.push_back(1);
      pulse(4'h2);
      wait_req("t4_req2", 8);
      cfg_wr(2'd2, 4'h2);
      wait_low("t4_w1c_withdraw", 4);
      rd(2'd3, rv); check("t4_pending_zero", 32'(rv), 32'd0);
      tick(4);

      // 5: disabled edge line stays pending, enabling raises req within 2 edges
      cfg_wr(2'd0, 4'h0); cfg_wr(2'd1, 4'h8);
      pulse(4'h8);
      tick(5);
      rd(2'd3, rv); check("t5_pending_disabled", 32'(rv), 32'd8);
      check("t5_no_req", 32'(irq_req), 32'd0);
      exp_q.push_back(3);
      cfg_wr(2'd0, 4'h8);
      tick(1);
      check("t5_req_on_enable", 32'(irq_req), 32'd1);
      do_ack(); do_done(); tick(2);

      // random rounds: all-edge lines, random enables and simultaneous pulses
      cfg_wr(2'd1, 4'hF);
      for (int r = 0; r < 20; r++) begin
         en = 4'($urandom);
         pm = 4'($urandom_range(1, 15));
         cfg_wr(2'd0, en);
         irq_ack = 1'b1; irq_done = 1'b1; tick(1); irq_ack = 1'b0; irq_done = 1'b0;
         check("rnd_stray_ignored", 32'(irq_req), 32'd0);
         nexp = 0;
         for (int i = 0; i < 4; i++) begin
            if (pm[i] && en[i]) begin exp_q.push_back(i); nexp++; end
         end
         pulse(pm);
         for (int k = 0; k < nexp; k++) begin
            wait_req("rnd_req", 12);
            do_ack();
            tick($urandom_range(0, 3));
            do_done();
         end
         tick(5);
         check("rnd_quiet", 32'(irq_req), 32'd0);
         rd(2'd3, rv); check("rnd_pending_left", 32'(rv), 32'(pm & ~en));
         cfg_wr(2'd2, 4'hF);
         rd(2'd3, rv); check("rnd_w1c_all", 32'(rv), 32'd0);
      end

      // 6: async reset during SERV discards everything
      cfg_wr(2'd0, 4'h1); cfg_wr(2'd1, 4'h5);
      exp_q.push_back(0);
      pulse(4'h5);
      wait_req("t6_req", 8);
      do_ack();
      rd(2'd3, rv); check("t6_pending_pre", 32'(rv), 32'd4);
      resetn = 1'b0;
      #1;
      check("t6_rst_req", 32'(irq_req), 32'd0);
      check("t6_rst_cause", 32'(irq_cause), 32'd8);
      rd(2'd3, rv); check("t6_rst_pending", 32'(rv), 32'd0);
      rd(2'd0, rv); check("t6_rst_enable", 32'(rv), 32'd0);
      tick(2);
      resetn = 1'b1;
      tick(2);
      pulse(4'h1);
      tick(8);
      check("t6_no_req_unconfigured", 32'(irq_req), 32'd0);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
